// File: rtl/picorv32_wb_pkg.sv
// Shared types for the PicoRV32 native-bus to Wishbone B4 master bridge.
package picorv32_wb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RETRY = 3'd3,
      ST_RESP  = 3'd4
   } wb_state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_BUS     = 2'b01,
      ERR_TIMEOUT = 2'b10,
      ERR_RETRY   = 2'b11
   } err_cause_t;

   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: loaded when stb asserts, counts down while the bridge waits
// for a termination, and flags the last allowed cycle.
module wb_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic wb_clk_i,
   input  logic wb_rst_i,
   input  logic load,
   input  logic enable,
   output logic expired
);

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_ctr
         localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
         logic [CW-1:0] count;

         // Holds cycles remaining after the current one; zero marks the final waiting cycle.
         always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i)
               count <= '0;
            else if (load)
               count <= CW'(TIMEOUT_CYCLES - 1);
            else if (enable && (count != '0))
               count <= count - CW'(1);
         end

         assign expired = enable && (count == '0);
      end else begin : g_off
         logic unused_tmo;
         assign unused_tmo = ^{wb_clk_i, wb_rst_i, load, enable};
         assign expired    = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/picorv32_wb_bridge.sv
// PicoRV32 native memory request to Wishbone B4 master (classic or pipelined),
// with err/rty handling, bus timeout and failure capture.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no request in flight; mem_valid sampled here only
// ST_REQ   | cyc+stb asserted; waiting for stall release or termination
// ST_WAIT  | pipelined only: stb accepted, cyc held until termination
// ST_RETRY | one-cycle cyc/stb gap after rty_i before re-issuing
// ST_RESP  | mem_ready pulse (plus bus_err_o on failure)
module picorv32_wb_bridge
   import picorv32_wb_pkg::*;
#(
   parameter int          ADDR_W         = 32,
   parameter bit          PIPELINED      = 1'b0,
   parameter int          TIMEOUT_CYCLES = 256,
   parameter int          MAX_RETRY      = 3,
   parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              mem_valid,
   input  logic              mem_instr,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   input  logic [3:0]        mem_wstrb,
   output logic              mem_ready,
   output logic [31:0]       mem_rdata,
   output logic [ADDR_W-1:0] wbm_adr_o,
   output logic [31:0]       wbm_dat_o,
   input  logic [31:0]       wbm_dat_i,
   output logic              wbm_we_o,
   output logic [3:0]        wbm_sel_o,
   output logic              wbm_stb_o,
   output logic              wbm_cyc_o,
   output logic              wbm_tga_o,
   input  logic              wbm_ack_i,
   input  logic              wbm_err_i,
   input  logic              wbm_rty_i,
   input  logic              wbm_stall_i,
   output logic              bus_err_o,
   output logic [31:0]       err_addr_o,
   output logic [1:0]        err_cause_o
);

   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   wb_state_e   state;
   logic [31:0] req_addr;
   logic [RW-1:0] retry_cnt;
   logic        busy;
   logic        tmo_load;
   logic        tmo_expired;
   logic        term_ok;
   logic        do_retry;
   err_cause_t  fail_cause;

   assign busy      = (state == ST_REQ) || (state == ST_WAIT);
   assign tmo_load  = ((state == ST_IDLE) && mem_valid) || (state == ST_RETRY);
   assign wbm_adr_o = req_addr[ADDR_W-1:0];

   wb_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_tmo (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .load     (tmo_load),
      .enable   (busy),
      .expired  (tmo_expired)
   );

   // Termination priority err > rty > ack; any termination beats a same-cycle timeout.
   always_comb begin
      term_ok    = 1'b0;
      do_retry   = 1'b0;
      fail_cause = ERR_NONE;
      if (busy) begin
         if (wbm_err_i)
            fail_cause = ERR_BUS;
         else if (wbm_rty_i) begin
            if (retry_cnt == RW'(MAX_RETRY))
               fail_cause = ERR_RETRY;
            else
               do_retry = 1'b1;
         end else if (wbm_ack_i)
            term_ok = 1'b1;
         else if (tmo_expired)
            fail_cause = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state       <= ST_IDLE;
         req_addr    <= '0;
         retry_cnt   <= '0;
         wbm_dat_o   <= '0;
         wbm_we_o    <= 1'b0;
         wbm_sel_o   <= 4'h0;
         wbm_stb_o   <= 1'b0;
         wbm_cyc_o   <= 1'b0;
         wbm_tga_o   <= 1'b0;
         mem_ready   <= 1'b0;
         mem_rdata   <= '0;
         bus_err_o   <= 1'b0;
         err_addr_o  <= '0;
         err_cause_o <= ERR_NONE;
      end else begin
         mem_ready <= 1'b0;
         bus_err_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (mem_valid) begin
                  req_addr  <= mem_addr;
                  wbm_dat_o <= mem_wdata;
                  wbm_tga_o <= mem_instr;
                  wbm_we_o  <= |mem_wstrb;
                  wbm_sel_o <= (|mem_wstrb) ? mem_wstrb : 4'hF;
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  state     <= ST_REQ;
               end
            end
            ST_REQ, ST_WAIT: begin
               if (term_ok || (fail_cause != ERR_NONE)) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  wbm_we_o  <= 1'b0;
                  mem_ready <= 1'b1;
                  state     <= ST_RESP;
                  if (fail_cause != ERR_NONE) begin
                     bus_err_o   <= 1'b1;
                     err_addr_o  <= req_addr;
                     err_cause_o <= fail_cause;
                     if (!wbm_we_o)
                        mem_rdata <= ERR_RDATA;
                  end else if (!wbm_we_o) begin
                     mem_rdata <= wbm_dat_i;
                  end
               end else if (do_retry) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  retry_cnt <= retry_cnt + RW'(1);
                  state     <= ST_RETRY;
               end else if (PIPELINED && (state == ST_REQ) && !wbm_stall_i) begin
                  wbm_stb_o <= 1'b0;
                  state     <= ST_WAIT;
               end
            end
            ST_RETRY: begin
               wbm_cyc_o <= 1'b1;
               wbm_stb_o <= 1'b1;
               state     <= ST_REQ;
            end
            ST_RESP: begin
               retry_cnt <= '0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_picorv32_wb_bridge.sv
// Bench for picorv32_wb_bridge: a classic and a pipelined instance driven by a
// scripted Wishbone slave, checked against a transaction-level outcome model.
module tb_picorv32_wb_bridge;

   localparam int          TO   = 8;
   localparam int          MR   = 3;
   localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        mem_valid [2];
   logic        mem_instr [2];
   logic [31:0] mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [3:0]  mem_wstrb [2];
   logic        mem_ready [2];
   logic [31:0] mem_rdata [2];
   logic [31:0] wbm_adr_o [2];
   logic [31:0] wbm_dat_o [2];
   logic [31:0] wbm_dat_i [2];
   logic        wbm_we_o  [2];
   logic [3:0]  wbm_sel_o [2];
   logic        wbm_stb_o [2];
   logic        wbm_cyc_o [2];
   logic        wbm_tga_o [2];
   logic        ack       [2];
   logic        err       [2];
   logic        rty       [2];
   logic        stall     [2];
   logic        bus_err_o [2];
   logic [31:0] err_addr_o  [2];
   logic [1:0]  err_cause_o [2];

   // transaction-level expectations carried between requests
   logic [31:0] m_rdata     [2];
   logic [31:0] m_err_addr  [2];
   logic [1:0]  m_err_cause [2];

   int n_pass;
   int n_total;

   always #5 wb_clk_i = ~wb_clk_i;

   picorv32_wb_bridge #(
      .ADDR_W(32), .PIPELINED(1'b0), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR), .ERR_RDATA(ERRV)
   ) u_classic (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .mem_valid(mem_valid[0]), .mem_instr(mem_instr[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]), .mem_ready(mem_ready[0]),
      .mem_rdata(mem_rdata[0]), .wbm_adr_o(wbm_adr_o[0]), .wbm_dat_o(wbm_dat_o[0]),
      .wbm_dat_i(wbm_dat_i[0]), .wbm_we_o(wbm_we_o[0]), .wbm_sel_o(wbm_sel_o[0]),
      .wbm_stb_o(wbm_stb_o[0]), .wbm_cyc_o(wbm_cyc_o[0]), .wbm_tga_o(wbm_tga_o[0]),
      .wbm_ack_i(ack[0]), .wbm_err_i(err[0]), .wbm_rty_i(rty[0]), .wbm_stall_i(stall[0]),
      .bus_err_o(bus_err_o[0]), .err_addr_o(err_addr_o[0]), .err_cause_o(err_cause_o[0])
   );

   picorv32_wb_bridge #(
      .ADDR_W(32), .PIPELINED(1'b1), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR), .ERR_RDATA(ERRV)
   ) u_pipe (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .mem_valid(mem_valid[1]), .mem_instr(mem_instr[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]), .mem_ready(mem_ready[1]),
      .mem_rdata(mem_rdata[1]), .wbm_adr_o(wbm_adr_o[1]), .wbm_dat_o(wbm_dat_o[1]),
      .wbm_dat_i(wbm_dat_i[1]), .wbm_we_o(wbm_we_o[1]), .wbm_sel_o(wbm_sel_o[1]),
      .wbm_stb_o(wbm_stb_o[1]), .wbm_cyc_o(wbm_cyc_o[1]), .wbm_tga_o(wbm_tga_o[1]),
      .wbm_ack_i(ack[1]), .wbm_err_i(err[1]), .wbm_rty_i(rty[1]), .wbm_stall_i(stall[1]),
      .bus_err_o(bus_err_o[1]), .err_addr_o(err_addr_o[1]), .err_cause_o(err_cause_o[1])
   );

   task automatic clear_model();
      for (int i = 0; i < 2; i++) begin
         m_rdata[i]     = '0;
         m_err_addr[i]  = '0;
         m_err_cause[i] = 2'b00;
      end
   endtask

   // One native request on instance d. Slave script: stall for the first stall_n cycles
   // of each cyc phase, terminate on cycle k of a phase (k=0: never); the first n_rty
   // phases end in rty, the next one in err (use_err) or ack.
   task automatic run_txn(input int d, input string tag, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input logic instr,
                          input logic [31:0] sdata, input int stall_n, input int k,
                          input int n_rty, input bit use_err);
      bit          is_wr, tmo, fail, got_berr, idle_bad, prev_cyc;
      int          L, P, exp_lat, exp_stb;
      logic [1:0]  cause, got_ecause;
      logic [31:0] exp_rdata, got_rdata, got_eaddr;
      int          c, phase, pcyc, gap, gap_bad, field_bad, stb_cnt, ready_cnt, ready_c, berr_cnt;

      is_wr = (wstrb != 4'h0);
      tmo   = (k == 0) || (k > TO);
      L     = tmo ? TO : k;
      if (tmo) begin
         P = 1; fail = 1'b1; cause = 2'b10;
      end else if (n_rty > MR) begin
         P = MR + 1; fail = 1'b1; cause = 2'b11;
      end else begin
         P = n_rty + 1; fail = use_err; cause = use_err ? 2'b01 : 2'b00;
      end
      exp_lat = P * L + P;
      exp_stb = P * (((d == 1) && (stall_n + 1 < L)) ? stall_n + 1 : L);
      exp_rdata = is_wr ? m_rdata[d] : (fail ? ERRV : sdata);
      m_rdata[d] = exp_rdata;
      if (fail) begin
         m_err_addr[d]  = addr;
         m_err_cause[d] = cause;
      end

      mem_addr[d] = addr; mem_wdata[d] = wdata; mem_wstrb[d] = wstrb;
      mem_instr[d] = instr; wbm_dat_i[d] = sdata; mem_valid[d] = 1'b1;
      c = 0; phase = 0; pcyc = 0; gap = 0; gap_bad = 0; field_bad = 0; stb_cnt = 0;
      ready_cnt = 0; ready_c = 0; berr_cnt = 0; prev_cyc = 1'b0; idle_bad = 1'b0;
      got_berr = 1'b0; got_rdata = '0; got_eaddr = '0; got_ecause = 2'b00;

      @(posedge wb_clk_i);
      while ((c < 150) && !((ready_cnt > 0) && (c > ready_c))) begin
         @(negedge wb_clk_i);
         c++;
         if (wbm_cyc_o[d] && !prev_cyc) begin
            if ((phase > 0) && (gap != 1)) gap_bad++;
            phase++; pcyc = 0; gap = 0;
         end
         if (!wbm_cyc_o[d] && (phase > 0)) gap++;
         if (wbm_cyc_o[d]) pcyc++;
         if (wbm_stb_o[d]) begin
            stb_cnt++;
            if (wbm_adr_o[d] !== addr || wbm_we_o[d] !== is_wr || wbm_tga_o[d] !== instr ||
                wbm_sel_o[d] !== (is_wr ? wstrb : 4'hF) || (is_wr && wbm_dat_o[d] !== wdata))
               field_bad++;
         end
         if (mem_ready[d]) begin
            ready_cnt++; ready_c = c;
            got_rdata = mem_rdata[d]; got_berr = bus_err_o[d];
            got_eaddr = err_addr_o[d]; got_ecause = err_cause_o[d];
            mem_valid[d] = 1'b0;
         end
         if (bus_err_o[d]) berr_cnt++;
         if ((ready_cnt > 0) && (c == ready_c + 1) && wbm_cyc_o[d]) idle_bad = 1'b1;
         ack[d] = 1'b0; err[d] = 1'b0; rty[d] = 1'b0;
         stall[d] = wbm_cyc_o[d] && (pcyc <= stall_n);
         if (wbm_cyc_o[d] && (pcyc == k)) begin
            if (phase <= n_rty)  rty[d] = 1'b1;
            else if (use_err)    err[d] = 1'b1;
            else                 ack[d] = 1'b1;
         end
         prev_cyc = wbm_cyc_o[d];
      end
      ack[d] = 1'b0; err[d] = 1'b0; rty[d] = 1'b0; stall[d] = 1'b0; mem_valid[d] = 1'b0;

      n_total++;
      if (ready_cnt !== 1) $display("FAIL %s ready_count: got %0d want 1", tag, ready_cnt);
      else n_pass++;
      n_total++;
      if (ready_c !== exp_lat) $display("FAIL %s ready_latency: got %0d want %0d", tag, ready_c, exp_lat);
      else n_pass++;
      n_total++;
      if (phase !== P) $display("FAIL %s cyc_phases: got %0d want %0d", tag, phase, P);
      else n_pass++;
      n_total++;
      if (gap_bad !== 0) $display("FAIL %s retry_gap: got %0d bad gaps want 0", tag, gap_bad);
      else n_pass++;
      n_total++;
      if (stb_cnt !== exp_stb) $display("FAIL %s stb_cycles: got %0d want %0d", tag, stb_cnt, exp_stb);
      else n_pass++;
      n_total++;
      if (field_bad !== 0) $display("FAIL %s bus_fields: got %0d bad cycles want 0", tag, field_bad);
      else n_pass++;
      n_total++;
      if (got_rdata !== exp_rdata) $display("FAIL %s mem_rdata: got %h want %h", tag, got_rdata, exp_rdata);
      else n_pass++;
      n_total++;
      if (got_berr !== fail || berr_cnt !== (fail ? 1 : 0))
         $display("FAIL %s bus_err: got %0b (%0d pulses) want %0b", tag, got_berr, berr_cnt, fail);
      else n_pass++;
      n_total++;
      if (got_eaddr !== m_err_addr[d]) $display("FAIL %s err_addr: got %h want %h", tag, got_eaddr, m_err_addr[d]);
      else n_pass++;
      n_total++;
      if (got_ecause !== m_err_cause[d]) $display("FAIL %s err_cause: got %b want %b", tag, got_ecause, m_err_cause[d]);
      else n_pass++;
      n_total++;
      if (idle_bad !== 1'b0) $display("FAIL %s idle_after_ready: got cyc=1 want cyc=0", tag);
      else n_pass++;
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1;
      #1;
      clear_model();
      for (int i = 0; i < 2; i++) begin
         n_total++;
         if ({wbm_cyc_o[i], wbm_stb_o[i], wbm_we_o[i], wbm_tga_o[i], mem_ready[i], bus_err_o[i]} !== 6'b0)
            $display("FAIL reset_ctrl[%0d]: got %b want 000000", i,
                     {wbm_cyc_o[i], wbm_stb_o[i], wbm_we_o[i], wbm_tga_o[i], mem_ready[i], bus_err_o[i]});
         else n_pass++;
         n_total++;
         if ({mem_rdata[i], err_addr_o[i], wbm_adr_o[i], wbm_dat_o[i]} !== 128'b0)
            $display("FAIL reset_data[%0d]: got rdata=%h eaddr=%h adr=%h dat=%h want 0", i,
                     mem_rdata[i], err_addr_o[i], wbm_adr_o[i], wbm_dat_o[i]);
         else n_pass++;
         n_total++;
         if ({wbm_sel_o[i], err_cause_o[i]} !== 6'b0)
            $display("FAIL reset_sel_cause[%0d]: got sel=%h cause=%b want 0", i, wbm_sel_o[i], err_cause_o[i]);
         else n_pass++;
      end
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
   endtask

   task automatic test_classic_read();
      run_txn(0, "classic_read", 32'h0000_0100, 32'h0, 4'h0, 1'b0, 32'h1234_5678, 0, 3, 0, 1'b0);
   endtask

   task automatic test_pipelined_write();
      run_txn(1, "pipe_write", 32'h0000_0040, 32'hCAFE_F00D, 4'b0011, 1'b0, 32'h5555_AAAA, 3, 5, 0, 1'b0);
      run_txn(0, "classic_sparse_write", 32'h0000_0044, 32'h0BAD_F00D, 4'b1000, 1'b0, 32'h0, 2, 2, 0, 1'b0);
   endtask

   task automatic test_err();
      run_txn(0, "err_read", 32'h2000_0000, 32'h0, 4'h0, 1'b0, 32'h7777_7777, 0, 2, 0, 1'b1);
      run_txn(1, "err_fetch_pipe", 32'h2000_0010, 32'h0, 4'h0, 1'b1, 32'h1111_1111, 1, 3, 0, 1'b1);
   endtask

   task automatic test_retry();
      run_txn(0, "retry_then_ack", 32'h0000_0200, 32'h0, 4'h0, 1'b1, 32'hA5A5_0001, 0, 1, 2, 1'b0);
      run_txn(0, "retry_exhausted", 32'h0000_0204, 32'h0, 4'h0, 1'b0, 32'hA5A5_0002, 0, 1, 4, 1'b0);
      run_txn(1, "retry_pipe", 32'h0000_0208, 32'h0, 4'h0, 1'b0, 32'hA5A5_0003, 1, 3, 1, 1'b0);
   endtask

   task automatic test_timeout();
      run_txn(0, "timeout_read", 32'h0000_0300, 32'h0, 4'h0, 1'b0, 32'h0, 0, 0, 0, 1'b0);
      run_txn(0, "ack_on_timeout_cycle", 32'h0000_0304, 32'h0, 4'h0, 1'b0, 32'h0F0F_0F0F, 0, TO, 0, 1'b0);
      run_txn(1, "timeout_pipe", 32'h0000_0308, 32'h0, 4'h0, 1'b0, 32'h0, 2, 0, 0, 1'b0);
      run_txn(0, "timeout_write", 32'h0000_030C, 32'h1234_0000, 4'hF, 1'b0, 32'h0, 0, TO + 1, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      int          d, stall_n, k, n_rty;
      logic [3:0]  wstrb;
      for (int t = 0; t < 40; t++) begin
         d       = $urandom_range(0, 1);
         wstrb   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         stall_n = $urandom_range(0, 3);
         k       = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(stall_n + 1, 9);
         n_rty   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 4);
         run_txn(d, "random", $urandom, $urandom, wstrb, 1'($urandom), $urandom,
                 stall_n, k, n_rty, ($urandom_range(0, 5) == 0));
      end
   endtask

   task automatic test_async_reset();
      mem_addr[1] = 32'h0000_0400; mem_wstrb[1] = 4'h0; mem_instr[1] = 1'b1;
      stall[1] = 1'b0; mem_valid[1] = 1'b1;
      repeat (3) @(posedge wb_clk_i);
      #2;
      n_total++;
      if ({wbm_cyc_o[1], wbm_stb_o[1]} !== 2'b10)
         $display("FAIL pre_reset_wait: got cyc/stb=%b want 10", {wbm_cyc_o[1], wbm_stb_o[1]});
      else n_pass++;
      wb_rst_i = 1'b1;
      #1;
      n_total++;
      if ({wbm_cyc_o[1], wbm_stb_o[1], mem_ready[1]} !== 3'b000)
         $display("FAIL async_reset: got cyc/stb/ready=%b want 000",
                  {wbm_cyc_o[1], wbm_stb_o[1], mem_ready[1]});
      else n_pass++;
      mem_valid[1] = 1'b0;
      clear_model();
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      run_txn(1, "after_reset", 32'h0000_0404, 32'h0, 4'h0, 1'b1, 32'h600D_CAFE, 0, 2, 0, 1'b0);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      for (int i = 0; i < 2; i++) begin
         mem_valid[i] = 1'b0; mem_instr[i] = 1'b0; mem_addr[i] = '0; mem_wdata[i] = '0;
         mem_wstrb[i] = 4'h0; wbm_dat_i[i] = '0; ack[i] = 1'b0; err[i] = 1'b0;
         rty[i] = 1'b0; stall[i] = 1'b0;
      end
      test_reset();
      test_classic_read();
      test_pipelined_write();
      test_err();
      test_retry();
      test_timeout();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
